// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, assembles 32-bit words from four byte reads, hands them to decode.
// Latency: 5 cycles from F0 to inst_valid; with inst_ready held high one instruction is accepted every 6 cycles.
// Backpressure: inst_ready low in V holds state, inst and inst_pc stable with no reads issued, indefinitely.
module fetch_sequencer #(
  parameter int          IMEM_BYTES = 4096,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          MAX_INSTR  = 30
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  output logic        imem_rd,
  input  logic [7:0]  imem_rdata,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        pc_src,
  input  logic [63:0] branch_addr,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_F0, S_F1, S_F2, S_F3, S_W, S_V, S_HALT, S_FAULT
  } state_t;

  // Highest PC from which a whole word still fits in memory.
  localparam logic [63:0] LAST_WORD_ADDR = 64'(IMEM_BYTES) - 64'd4;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic [23:0] low_bytes;   // bytes 0..2 of the word being assembled
  logic [31:0] word;        // full word as seen at the end of W
  logic [31:0] count_inc;
  logic        addr_bad;
  logic        handshake;
  logic        limit_hit;

  assign word      = {imem_rdata, low_bytes};
  assign count_inc = instr_count + 32'd1;
  // Misaligned or out-of-range PCs (including wrapped PC+4) are rejected before any read.
  assign addr_bad  = (pc[1:0] != 2'b00) || (pc > LAST_WORD_ADDR);
  assign handshake = inst_valid && inst_ready;
  assign limit_hit = (MAX_INSTR != 0) && (count_inc == 32'(MAX_INSTR));

  // Status outputs are pure state decodes, forced low while reset is held.
  assign inst_valid = (state == S_V) && !rst;
  assign halted     = (state == S_HALT) && !rst;
  assign fault      = (state == S_FAULT) && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_F0;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and memory read strobe/address for the current fetch step.
  always_comb begin
    state_next = state;
    imem_rd    = 1'b0;
    imem_addr  = 64'h0;
    case (state)
      S_F0: begin
        if (addr_bad) begin
          state_next = S_FAULT;
        end else begin
          imem_rd    = 1'b1;
          imem_addr  = pc;
          state_next = S_F1;
        end
      end
      S_F1: begin
        imem_rd    = 1'b1;
        imem_addr  = pc + 64'd1;
        state_next = S_F2;
      end
      S_F2: begin
        imem_rd    = 1'b1;
        imem_addr  = pc + 64'd2;
        state_next = S_F3;
      end
      S_F3: begin
        imem_rd    = 1'b1;
        imem_addr  = pc + 64'd3;
        state_next = S_W;
      end
      S_W: begin
        // HALT opcode: the word is dropped and never presented to decode.
        state_next = (word[31:21] == 11'h7FF) ? S_HALT : S_V;
      end
      S_V: begin
        if (inst_ready) begin
          state_next = limit_hit ? S_HALT : S_F0;
        end
      end
      default: begin
        state_next = state;
      end
    endcase
    // No read may escape while reset is asserted.
    if (rst) begin
      imem_rd   = 1'b0;
      imem_addr = 64'h0;
    end
  end

  // Datapath: byte capture, word presentation, PC update and handshake counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      low_bytes   <= 24'h0;
      inst        <= 32'h0;
      inst_pc     <= 64'h0;
      instr_count <= 32'h0;
    end else begin
      case (state)
        S_F1: low_bytes[7:0]   <= imem_rdata;
        S_F2: low_bytes[15:8]  <= imem_rdata;
        S_F3: low_bytes[23:16] <= imem_rdata;
        S_W: begin
          if (state_next == S_V) begin
            inst    <= word;
            inst_pc <= pc;
          end
        end
        S_V: begin
          if (handshake) begin
            pc          <= pc_src ? branch_addr : pc + 64'd4;
            instr_count <= count_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
